// File: rtl/bus_arbiter_param.sv
// N-master bus arbiter: fixed-priority or round-robin, bounded tenure with timeout.
// Latency: request sampled -> registered grant 1 cycle later; at least 1 idle cycle between tenures.
// Backpressure: requests wait pending while another master owns the bus; no preemption except timeout.
module bus_arbiter_param #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_W        = 3,
    parameter int RR_MODE     = 1,
    parameter int MAX_HOLD    = 16,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] m_req,
    output logic [NUM_MASTERS-1:0] m_grant,
    output logic [ID_W-1:0]        grant_id,
    output logic                   bus_busy,
    output logic [NUM_MASTERS-1:0] m_busy,
    output logic [NUM_MASTERS-1:0] m_timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [NUM_MASTERS-1:0] ONE       = NUM_MASTERS'(1);
    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam bit                     TMO_EN    = (MAX_HOLD != 0);

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant_nxt, tmo_nxt;
    logic [NUM_MASTERS-1:0] excl, excl_nxt;
    logic [NUM_MASTERS-1:0] others, elig, win_oh;
    logic [ID_W-1:0]        id_nxt, last, last_nxt, win_id;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   win_vld, rel_hit;

    // Search position k of the arbitration order; RR starts just after the last winner.
    function automatic int search_pos(input int k, input logic [ID_W-1:0] base);
        int s;
        if (RR_MODE != 0) begin
            s = int'(base) + 1 + k;
            if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        end else begin
            s = k;
        end
        return s;
    endfunction

    // A master that just timed out only competes when nobody else is asking.
    always_comb begin
        others  = m_req & ~excl;
        elig    = (|others) ? others : m_req;
        win_vld = |elig;
        win_id  = '0;
        win_oh  = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (|(elig & (ONE << search_pos(k, last)))) begin
                win_id = ID_W'(search_pos(k, last));
                win_oh = ONE << search_pos(k, last);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = m_grant;
        id_nxt    = grant_id;
        cnt_nxt   = cnt;
        last_nxt  = last;
        excl_nxt  = excl;
        tmo_nxt   = '0;
        rel_hit   = ~|(m_req & m_grant);
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                    grant_nxt = win_oh;
                    id_nxt    = win_id;
                    cnt_nxt   = '0;
                    last_nxt  = win_id;
                    excl_nxt  = '0;
                end
            end
            GRANT: begin
                // Release wins over a coincident timeout, so no pulse in that case.
                if (rel_hit) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    id_nxt    = '0;
                end else if (TMO_EN && (cnt == HOLD_LAST)) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    id_nxt    = '0;
                    tmo_nxt   = m_grant;
                    excl_nxt  = m_grant;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            m_grant   <= '0;
            grant_id  <= '0;
            cnt       <= '0;
            last      <= ID_W'(NUM_MASTERS - 1);
            excl      <= '0;
            m_timeout <= '0;
        end else begin
            state     <= state_nxt;
            m_grant   <= grant_nxt;
            grant_id  <= id_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            excl      <= excl_nxt;
            m_timeout <= tmo_nxt;
        end
    end

    assign bus_busy = |m_grant;
    assign m_busy   = m_req | m_grant;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// Bench for bus_arbiter_param: three configurations driven in lockstep and compared
// every cycle against an integer-level arbitration model.
module tb_bus_arbiter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req_a, req_b;
    logic [1:0] req_c;
    logic [3:0] gnt_a, mb_a, to_a, gnt_b, mb_b, to_b;
    logic [1:0] gnt_c, mb_c, to_c;
    logic [2:0] id_a, id_b, id_c;
    logic       bb_a, bb_b, bb_c;

    int n_pass  = 0;
    int n_total = 0;

    bus_arbiter_param #(.NUM_MASTERS(4), .ID_W(3), .RR_MODE(1), .MAX_HOLD(5), .CNT_W(8)) u_a (
        .clk(clk), .reset(rst), .m_req(req_a), .m_grant(gnt_a), .grant_id(id_a),
        .bus_busy(bb_a), .m_busy(mb_a), .m_timeout(to_a));
    bus_arbiter_param #(.NUM_MASTERS(4), .ID_W(3), .RR_MODE(0), .MAX_HOLD(0), .CNT_W(8)) u_b (
        .clk(clk), .reset(rst), .m_req(req_b), .m_grant(gnt_b), .grant_id(id_b),
        .bus_busy(bb_b), .m_busy(mb_b), .m_timeout(to_b));
    bus_arbiter_param #(.NUM_MASTERS(2), .ID_W(3), .RR_MODE(1), .MAX_HOLD(0), .CNT_W(8)) u_c (
        .clk(clk), .reset(rst), .m_req(req_c), .m_grant(gnt_c), .grant_id(id_c),
        .bus_busy(bb_c), .m_busy(mb_c), .m_timeout(to_c));

    // g: granted master or -1; held: cycles the grant has been visible, counting the current one.
    typedef struct {
        int g;
        int held;
        int last;
        int excl;
        int to;
    } mdl_t;

    mdl_t sa, sb, sc;

    function automatic bit bit_set(input logic [7:0] v, input int i);
        return ((v >> i) & 8'd1) != 8'd0;
    endfunction

    function automatic mdl_t mdl_reset(input int n);
        mdl_t r;
        r.g = -1; r.held = 0; r.last = n - 1; r.excl = -1; r.to = -1;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t s, input logic [7:0] req, input int n,
                                      input bit rr, input int mh, input bit rs);
        mdl_t r;
        int best, bestd, d;
        if (rs) return mdl_reset(n);
        r = s;
        r.to = -1;
        if (s.g < 0) begin
            best = -1;
            bestd = 1000;
            for (int i = 0; i < n; i++) begin
                if (bit_set(req, i) && i != s.excl) begin
                    d = rr ? (i - s.last - 1 + 2 * n) % n : i;
                    if (d < bestd) begin bestd = d; best = i; end
                end
            end
            if (best < 0 && s.excl >= 0 && bit_set(req, s.excl)) best = s.excl;
            if (best >= 0) begin
                r.g = best; r.held = 1; r.last = best; r.excl = -1;
            end
        end else if (!bit_set(req, s.g)) begin
            r.g = -1;
        end else if (mh != 0 && s.held >= mh) begin
            r.to = s.g; r.excl = s.g; r.g = -1;
        end else begin
            r.held = s.held + 1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_inst(input string nm, input mdl_t s, input logic [7:0] req,
                              input logic [7:0] gnt, input logic [7:0] id, input logic [7:0] bb,
                              input logic [7:0] mb, input logic [7:0] tov);
        logic [7:0] eg, et;
        eg = (s.g >= 0) ? (8'd1 << s.g) : 8'd0;
        et = (s.to >= 0) ? (8'd1 << s.to) : 8'd0;
        check({nm, ".grant"}, gnt, eg);
        check({nm, ".grant_id"}, id, (s.g >= 0) ? 8'(s.g) : 8'd0);
        check({nm, ".bus_busy"}, bb, (s.g >= 0) ? 8'd1 : 8'd0);
        check({nm, ".m_busy"}, mb, req | eg);
        check({nm, ".m_timeout"}, tov, et);
        check({nm, ".inv_onehot"}, {7'b0, $onehot0(gnt)}, 8'd1);
        check({nm, ".inv_busy"}, {7'b0, bb[0] == (|gnt)}, 8'd1);
        check({nm, ".inv_id"}, {7'b0, (gnt == 8'd0) ? (id == 8'd0) : (gnt == (8'd1 << id))}, 8'd1);
    endtask

    task automatic step();
        @(posedge clk);
        sa = mdl_step(sa, 8'(req_a), 4, 1'b1, 5, rst);
        sb = mdl_step(sb, 8'(req_b), 4, 1'b0, 0, rst);
        sc = mdl_step(sc, 8'(req_c), 2, 1'b1, 0, rst);
        #1;
        check_inst("a", sa, 8'(req_a), 8'(gnt_a), 8'(id_a), 8'(bb_a), 8'(mb_a), 8'(to_a));
        check_inst("b", sb, 8'(req_b), 8'(gnt_b), 8'(id_b), 8'(bb_b), 8'(mb_b), 8'(to_b));
        check_inst("c", sc, 8'(req_c), 8'(gnt_c), 8'(id_c), 8'(bb_c), 8'(mb_c), 8'(to_c));
    endtask

    initial begin
        int order_q[$];
        int exp_order[5];
        int len;
        logic prev_bb;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset
        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
        sa = mdl_reset(4); sb = mdl_reset(4); sc = mdl_reset(2);
        step(); step();
        rst = 1'b0;
        step();

        // Two-master single-cycle pulses
        req_c = 2'b01; step();
        req_c = 2'b00; step(); step();
        req_c = 2'b10; step();
        req_c = 2'b00; step(); step();

        // RR rotation on a, fixed priority with late high-priority request on b
        prev_bb = 1'b0;
        for (int k = 0; k < 24; k++) begin
            req_a = 4'hF;
            if (sa.g >= 0 && sa.held == 3) req_a = 4'hF & ~(4'd1 << sa.g);
            if (k == 0) req_b = 4'b1110;
            if (k == 4) begin
                req_b[0] = 1'b1;
                #1;
                check("b.m_busy_pending", 8'(mb_b[0]), 8'd1);
            end
            if (k == 8) req_b[1] = 1'b0;
            step();
            if (bb_a && !prev_bb) order_q.push_back(int'(id_a));
            prev_bb = bb_a;
        end
        check("a.rr_grant_count", {7'b0, order_q.size() >= 5}, 8'd1);
        for (int i = 0; i < 5; i++)
            check("a.rr_order", 8'((i < order_q.size()) ? order_q[i] : -1), 8'(exp_order[i]));
        check("b.fixed_after_release", 8'(gnt_b), 8'b0001);

        // Timeout with a competing requester
        rst = 1'b1; req_a = '0; req_b = '0; step();
        rst = 1'b0;
        req_a = 4'b0011;
        for (int i = 0; i < 4 && !gnt_a[0]; i++) step();
        len = 0;
        while (gnt_a[0] && len < 20) begin len++; step(); end
        check("a.tenure_len", 8'(len), 8'd5);
        check("a.timeout_pulse", 8'(to_a), 8'b0001);
        step();
        check("a.next_after_timeout", 8'(gnt_a), 8'b0010);
        req_a = 4'b0001;
        for (int i = 0; i < 16; i++) step();

        // Release on the same edge the tenure limit is reached
        rst = 1'b1; req_a = '0; step();
        rst = 1'b0;
        req_a = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            if (sa.g == 0 && sa.held == 5) break;
        end
        req_a = 4'b0000;
        step();
        check("a.release_no_timeout", 8'(to_a), 8'd0);
        check("a.release_grant", 8'(gnt_a), 8'd0);
        step();

        // Reset on the second cycle of a tenure
        req_a = 4'hF;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("a.first_after_reset", 8'(id_a), 8'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            req_a ^= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req_b ^= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            req_c ^= 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_param.md
Name: bus_arbiter_param

Overview:
- Parametrised N-master system bus arbiter. Successor to the fixed two-master arbitration inside the bus top level.
- Accepts one request line per master and issues a one-hot grant plus an encoded grant ID that drive the bus address/data muxes.
- Adds a selectable fixed-priority or round-robin policy, a bounded bus tenure with timeout, and per-master busy indication.

Parameters:
- NUM_MASTERS, 2, number of masters; legal range 2..8.
- ID_W, 3, width of grant_id; must satisfy 2^ID_W >= NUM_MASTERS.
- RR_MODE, 1, 0 = fixed priority (master 0 highest); 1 = round-robin.
- MAX_HOLD, 16, maximum consecutive granted cycles per tenure; 0 disables the timeout.
- CNT_W, 8, width of the tenure counter; must satisfy MAX_HOLD < 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m_req  input  NUM_MASTERS  request per master; held high for the whole transaction.
- m_grant  output  NUM_MASTERS  one-hot grant, registered.
- grant_id  output  ID_W  index of the granted master; 0 when no grant.
- bus_busy  output  1  high while any grant is active.
- m_busy  output  NUM_MASTERS  per master: high while requesting but not granted, or while granted.
- m_timeout  output  NUM_MASTERS  one-cycle pulse to a master whose grant was revoked by timeout.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset sampled on the clk rising edge).
- Reset values: m_grant = 0, grant_id = 0, bus_busy = 0, m_timeout = 0, tenure counter = 0, state = IDLE, RR pointer last = NUM_MASTERS-1 (master 0 wins first). m_busy follows its combinational definition from m_req and m_grant, so it reads m_req while reset holds m_grant at 0.
- Reset mid-tenure drops the grant on the next edge with no timeout pulse.
- States:
  - IDLE: m_grant = 0.
  - GRANT: exactly one m_grant bit high.
- IDLE -> GRANT:
  - Any eligible m_req bit high at a rising edge asserts the winner's grant on that edge. Latency is 1 cycle from request sampled to grant visible.
  - Fixed mode: the lowest index wins.
  - RR mode: search starts at (last+1) mod NUM_MASTERS. last updates to the winner.
- GRANT -> IDLE on either condition:
  - Normal release: the granted master's m_req is sampled low. The grant clears on that edge.
  - Timeout: MAX_HOLD != 0 and the grant has been high for MAX_HOLD cycles. The grant clears, m_timeout[winner] pulses high for 1 cycle, aligned with the first cycle of grant low.
- Turnaround: IDLE always lasts at least 1 cycle between tenures (no back-to-back grant switching). This guarantees bus mux settling.
- Tenure counter: cleared on entry to GRANT, incremented each granted cycle, saturates at 2^CNT_W-1.
- Release and timeout on the same edge: treated as a normal release; no m_timeout pulse.
- Timed-out master eligibility:
  - It is excluded from the next arbitration if any other m_req is high. If it is the only requester, it is re-granted after the 1-cycle turnaround.
  - This applies in both modes, so fixed mode cannot starve others via timeout.
- A master's m_req rising while another master is granted is held pending. m_busy goes high in the same cycle, combinationally from m_req and m_grant.
- m_req bits at index >= NUM_MASTERS do not exist. grant_id never exceeds NUM_MASTERS-1.
- Invariants (assert in bench):
  - m_grant is one-hot or zero.
  - bus_busy == |m_grant.
  - grant_id matches m_grant.

Test Plan:
- NUM_MASTERS=2, RR_MODE=1, MAX_HOLD=0; m_req[0] high for 1 cycle then low (button-style pulse), later m_req[1] likewise -> m_grant = 01 for 1 cycle, then 00; later m_grant = 10 for 1 cycle; grant_id 0 then 1; bus_busy mirrors.
- NUM_MASTERS=4, RR_MODE=1; all m_req held high, each master drops m_req 3 cycles after its grant -> grant order 0,1,2,3,0. Each tenure is 3 cycles with 1 idle cycle between.
- NUM_MASTERS=4, RR_MODE=0; m_req = 1110 held, then m_req[0] raised during master 1's tenure -> the next grant after master 1 releases goes to master 0, not master 2. m_busy[0] is high from the cycle m_req[0] rises.
- MAX_HOLD=5, NUM_MASTERS=2; m_req[0] held forever, m_req[1] high -> m_grant[0] high exactly 5 cycles, m_timeout[0] pulses 1 cycle, master 1 granted after 1 idle cycle. With m_req[1] low, master 0 is re-granted after 1 idle cycle.
- MAX_HOLD=5; master 0 drops m_req on the same edge the count reaches 5 -> grant clears, m_timeout stays 0.
- Reset asserted on the 2nd cycle of a tenure -> m_grant, grant_id, bus_busy and m_timeout are 0 on the next edge. After release with all m_req high in RR mode, master 0 is granted first.
